seq_det_ctrl: RTL and testbench

Run controller for the serial bit-stream pattern detector.
- Holds a programmable pattern (up to PAT_W bits), its length and a match policy.
- On start, samples the serial input `in`, pulses `out` on each match and counts matches.
- Finishes on reaching the match target or a cycle timeout, then reports done and status.
- Sits between the config/control master and the serial stream source.

---
 rtl/seq_det_pkg.sv | 31 +++
 rtl/seq_match_window.sv | 77 +++++++
 rtl/seq_det_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared types and constants for the serial pattern detector run controller.
//   - state_e     : controller states (idle, running, one-cycle done)
//   - DEF_*       : configuration values loaded by reset
//   - clampLen    : folds a requested pattern length into the legal 1..maxLen range
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_LEN     = 1;
    localparam int unsigned DEF_TARGET  = 1;
    localparam bit          DEF_OVERLAP = 1'b1;
    localparam int unsigned DEF_TIMEOUT = 0;

    // A zero length would never match anything, so it is treated as one bit;
    // lengths beyond the window are limited to the window size.
    function automatic int unsigned clampLen(input int unsigned len, input int unsigned maxLen);
        if (len == 0) begin
            return 1;
        end
        if (len > maxLen) begin
            return maxLen;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_match_window.sv
// seq_match_window
//   Shift-register window over the serial stream with a fill counter and a
//   length-masked comparison against the programmed pattern. The match output
//   is combinational and describes the state the window is about to take on the
//   coming edge, so the controller can register the match pulse on that edge.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   shift_en_i  shift in_i into the window on this edge
//   clr_i       clear window and fill counter (wins over shifting)
//   fill_clr_i  restart the fill counter on this shift (non-overlapping mode)
//   len_i       pattern length, already clamped to 1..PAT_W
//   pat_i       pattern, first received bit is compared with pat_i[len-1]
//   in_i        serial data bit
//   match_o     the window after this edge equals the pattern
module seq_match_window
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             shift_en_i,
    input  logic             clr_i,
    input  logic             fill_clr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic             in_i,
    output logic             match_o
);

    logic [PAT_W-1:0] window_q;
    logic [PAT_W-1:0] window_d;
    logic [LEN_W-1:0] fill_q;
    logic [LEN_W-1:0] fill_d;
    logic [PAT_W-1:0] lenMask;

    // The newest bit lands in bit 0, so after len shifts the oldest bit of the
    // pattern sits at position len-1, lining up with pat_i[len-1].
    always_comb begin
        window_d = {window_q[PAT_W-2:0], in_i};
        if (fill_q >= len_i) begin
            fill_d = len_i;
        end else begin
            fill_d = fill_q + LEN_W'(1);
        end
    end

    // Only the low len bits take part in the comparison.
    always_comb begin
        lenMask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            lenMask[i] = (i < int'(len_i));
        end
    end

    assign match_o = shift_en_i && (fill_d >= len_i) &&
                     ((window_d & lenMask) == (pat_i & lenMask));

    // Gaps in the stream (shift_en_i low) leave window and fill untouched so a
    // partial match survives them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            window_q <= '0;
            fill_q   <= '0;
        end else if (clr_i) begin
            window_q <= '0;
            fill_q   <= '0;
        end else if (shift_en_i) begin
            window_q <= window_d;
            fill_q   <= fill_clr_i ? '0 : fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl
//   Run controller for the serial bit-stream pattern detector. Holds the
//   programmed pattern, length and match policy; on start it watches the
//   serial input, pulses out_o on every match, counts matches and finishes on
//   the match target or a cycle timeout.
//
// Ports
//   clk_i / rst_ni      clock (rising edge) / asynchronous active-low reset
//   cfg_we_i            config write strobe, accepted only while idle
//   cfg_pat_i           pattern, MSB-first
//   cfg_len_i           pattern length (0 -> 1, >PAT_W -> PAT_W)
//   cfg_target_i        matches to finish, 0 = no target
//   cfg_overlap_i       1 = overlapping matches allowed
//   cfg_timeout_i       max run cycles, 0 = no timeout
//   start_i / abort_i   begin run (idle only) / cancel run
//   in_i / in_valid_i   serial data bit and its qualifier
//   busy_o              high while running
//   done_o              one-cycle completion pulse
//   out_o               one-cycle match pulse
//   match_cnt_o         matches this run, saturating
//   timed_out_o         run ended by timeout
//   cfg_err_o           sticky: config write attempted while not idle
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_we_i,
    input  logic [PAT_W-1:0] cfg_pat_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic [CNT_W-1:0] cfg_target_i,
    input  logic             cfg_overlap_i,
    input  logic [TMO_W-1:0] cfg_timeout_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             in_i,
    input  logic             in_valid_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             out_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             timed_out_o,
    output logic             cfg_err_o
);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             overlap_q, overlap_d;
    logic [TMO_W-1:0] timeout_q, timeout_d;
    logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;
    logic [CNT_W-1:0] matchCnt_q, matchCnt_d;
    logic             out_q, out_d;
    logic             timedOut_q, timedOut_d;
    logic             cfgErr_q, cfgErr_d;

    logic [LEN_W-1:0] cfgLenClamped;
    logic             winShift;
    logic             winClr;
    logic             winFillClr;
    logic             winMatch;

    assign cfgLenClamped = LEN_W'(clampLen(32'(cfg_len_i), PAT_W));

    assign winShift   = (state_q == ST_RUN) && in_valid_i;
    assign winClr     = (state_q == ST_IDLE) && start_i;
    assign winFillClr = winMatch && !overlap_q;

    seq_match_window #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_window (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .shift_en_i (winShift),
        .clr_i      (winClr),
        .fill_clr_i (winFillClr),
        .len_i      (len_q),
        .pat_i      (pat_q),
        .in_i       (in_i),
        .match_o    (winMatch)
    );

    // Next-state and status logic. Abort beats everything in RUN and drops the
    // match seen on its edge; when target and timeout land on the same edge the
    // target wins and the match is still counted.
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        target_d   = target_q;
        overlap_d  = overlap_q;
        timeout_d  = timeout_q;
        tmoCnt_d   = tmoCnt_q;
        matchCnt_d = matchCnt_q;
        out_d      = 1'b0;
        timedOut_d = timedOut_q;
        cfgErr_d   = cfgErr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_we_i) begin
                    pat_d     = cfg_pat_i;
                    len_d     = cfgLenClamped;
                    target_d  = cfg_target_i;
                    overlap_d = cfg_overlap_i;
                    timeout_d = cfg_timeout_i;
                end
                if (start_i) begin
                    state_d    = ST_RUN;
                    tmoCnt_d   = '0;
                    matchCnt_d = '0;
                    timedOut_d = 1'b0;
                    cfgErr_d   = 1'b0;
                end
            end

            ST_RUN: begin
                if (cfg_we_i) begin
                    cfgErr_d = 1'b1;
                end
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    tmoCnt_d = tmoCnt_q + TMO_W'(1);
                    if (winMatch) begin
                        out_d = 1'b1;
                        if (matchCnt_q != '1) begin
                            matchCnt_d = matchCnt_q + CNT_W'(1);
                        end
                    end
                    if ((target_q != '0) && (matchCnt_d == target_q)) begin
                        state_d    = ST_DONE;
                        timedOut_d = 1'b0;
                    end else if ((timeout_q != '0) && (tmoCnt_d == timeout_q)) begin
                        state_d    = ST_DONE;
                        timedOut_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                if (cfg_we_i) begin
                    cfgErr_d = 1'b1;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            pat_q      <= '0;
            len_q      <= LEN_W'(DEF_LEN);
            target_q   <= CNT_W'(DEF_TARGET);
            overlap_q  <= DEF_OVERLAP;
            timeout_q  <= TMO_W'(DEF_TIMEOUT);
            tmoCnt_q   <= '0;
            matchCnt_q <= '0;
            out_q      <= 1'b0;
            timedOut_q <= 1'b0;
            cfgErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            target_q   <= target_d;
            overlap_q  <= overlap_d;
            timeout_q  <= timeout_d;
            tmoCnt_q   <= tmoCnt_d;
            matchCnt_q <= matchCnt_d;
            out_q      <= out_d;
            timedOut_q <= timedOut_d;
            cfgErr_q   <= cfgErr_d;
        end
    end

    assign busy_o      = (state_q == ST_RUN);
    assign done_o      = (state_q == ST_DONE);
    assign out_o       = out_q;
    assign match_cnt_o = matchCnt_q;
    assign timed_out_o = timedOut_q;
    assign cfg_err_o   = cfgErr_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl
//   Directed bench for seq_det_ctrl: reset mid-run, overlapping and
//   non-overlapping matches, timeout, gaps plus abort, and config writes
//   during a run versus while idle.
module tb_seq_det_ctrl;

    localparam int PAT_W = 8;
    localparam int CNT_W = 8;
    localparam int TMO_W = 16;
    localparam int LEN_W = $clog2(PAT_W) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfgWe;
    logic [PAT_W-1:0] cfgPat;
    logic [LEN_W-1:0] cfgLen;
    logic [CNT_W-1:0] cfgTarget;
    logic             cfgOverlap;
    logic [TMO_W-1:0] cfgTimeout;
    logic             start;
    logic             abort;
    logic             inBit;
    logic             inValid;
    logic             busy;
    logic             done;
    logic             outPulse;
    logic [CNT_W-1:0] matchCnt;
    logic             timedOut;
    logic             cfgErr;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    seq_det_ctrl #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W),
        .TMO_W (TMO_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cfg_we_i      (cfgWe),
        .cfg_pat_i     (cfgPat),
        .cfg_len_i     (cfgLen),
        .cfg_target_i  (cfgTarget),
        .cfg_overlap_i (cfgOverlap),
        .cfg_timeout_i (cfgTimeout),
        .start_i       (start),
        .abort_i       (abort),
        .in_i          (inBit),
        .in_valid_i    (inValid),
        .busy_o        (busy),
        .done_o        (done),
        .out_o         (outPulse),
        .match_cnt_o   (matchCnt),
        .timed_out_o   (timedOut),
        .cfg_err_o     (cfgErr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkStatus(input string tag, input logic expBusy, input logic expDone,
                               input logic expOut, input int expCnt, input logic expTmo);
        checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
        checkOutput({tag, ".done"}, 32'(done), 32'(expDone));
        checkOutput({tag, ".out"}, 32'(outPulse), 32'(expOut));
        checkOutput({tag, ".cnt"}, 32'(matchCnt), 32'(expCnt));
        checkOutput({tag, ".tmo"}, 32'(timedOut), 32'(expTmo));
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic b, input logic v);
        inBit   = b;
        inValid = v;
        tick();
        inValid = 1'b0;
    endtask

    task automatic applyConfig(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                               input logic [CNT_W-1:0] t, input logic o, input logic [TMO_W-1:0] tm);
        cfgPat     = p;
        cfgLen     = l;
        cfgTarget  = t;
        cfgOverlap = o;
        cfgTimeout = tm;
        cfgWe      = 1'b1;
        tick();
        cfgWe      = 1'b0;
    endtask

    task automatic startRun();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [6:0]  bits2;
        logic [6:0]  outs2;
        logic [10:0] bits3;
        logic [10:0] outs3;
        logic [3:0]  bits6;
        logic [3:0]  outs6;

        rst_n = 1'b0;
        cfgWe = 1'b0; cfgPat = '0; cfgLen = '0; cfgTarget = '0;
        cfgOverlap = 1'b0; cfgTimeout = '0;
        start = 1'b0; abort = 1'b0; inBit = 1'b0; inValid = 1'b0;

        // Reset, then a run that builds match_cnt=3 and cfg_err=1 before a mid-run reset
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkStatus("t1.por", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("t1.por.cfgErr", 32'(cfgErr), 32'd0);

        applyConfig(8'h01, 4'd1, 8'd0, 1'b1, 16'd0);
        startRun();
        checkOutput("t1.busy", 32'(busy), 32'd1);
        applyConfig(8'h00, 4'd1, 8'd1, 1'b1, 16'd0);
        checkOutput("t1.cfgErr", 32'(cfgErr), 32'd1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkStatus("t1.prerst", 1'b1, 1'b0, 1'b1, 3, 1'b0);

        #2;
        rst_n = 1'b0;
        #1;
        checkStatus("t1.rst", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("t1.rst.cfgErr", 32'(cfgErr), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();
        checkStatus("t1.idle", 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Defaults after reset: pat=0, len=1, target=1 -> first 0 bit finishes the run
        startRun();
        applyStimulus(1'b0, 1'b1);
        checkStatus("t1.def", 1'b0, 1'b1, 1'b1, 1, 1'b0);
        tick();
        checkStatus("t1.def.after", 1'b0, 1'b0, 1'b0, 1, 1'b0);

        // Overlapping 1011 in 1011011, target 2
        applyConfig(8'h0B, 4'd4, 8'd2, 1'b1, 16'd0);
        startRun();
        checkStatus("t2.start", 1'b1, 1'b0, 1'b0, 0, 1'b0);
        bits2 = 7'b1011011;
        outs2 = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            applyStimulus(bits2[i], 1'b1);
            checkOutput("t2.out", 32'(outPulse), 32'(outs2[i]));
            checkOutput("t2.done", 32'(done), (i == 0) ? 32'd1 : 32'd0);
        end
        checkStatus("t2.end", 1'b0, 1'b1, 1'b1, 2, 1'b0);
        tick();
        checkStatus("t2.idle", 1'b0, 1'b0, 1'b0, 2, 1'b0);

        // Non-overlapping: second match needs four fresh bits
        applyConfig(8'h0B, 4'd4, 8'd2, 1'b0, 16'd0);
        startRun();
        bits3 = 11'b10110111011;
        outs3 = 11'b00010000001;
        for (int i = 10; i >= 0; i--) begin
            applyStimulus(bits3[i], 1'b1);
            checkOutput("t3.out", 32'(outPulse), 32'(outs3[i]));
            checkOutput("t3.done", 32'(done), (i == 0) ? 32'd1 : 32'd0);
        end
        checkStatus("t3.end", 1'b0, 1'b1, 1'b1, 2, 1'b0);
        tick();

        // Timeout after 5 RUN edges with no matches
        applyConfig(8'h00, 4'd2, 8'd3, 1'b1, 16'd5);
        startRun();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkStatus("t4.run", 1'b1, 1'b0, 1'b0, 0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1);
        checkStatus("t4.tmo", 1'b0, 1'b1, 1'b0, 0, 1'b1);
        tick();
        checkStatus("t4.hold", 1'b0, 1'b0, 1'b0, 0, 1'b1);

        // Gaps keep a partial match; config write in RUN is ignored; abort drops its match
        applyConfig(8'h03, 4'd2, 8'd0, 1'b1, 16'd0);
        startRun();
        checkStatus("t5.start", 1'b1, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t5.b1.out", 32'(outPulse), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("t5.gap.out", 32'(outPulse), 32'd0);
        end
        applyStimulus(1'b1, 1'b1);
        checkStatus("t5.match", 1'b1, 1'b0, 1'b1, 1, 1'b0);

        applyConfig(8'h00, 4'd0, 8'd1, 1'b1, 16'd0);
        checkOutput("t6.run.cfgErr", 32'(cfgErr), 32'd1);
        checkOutput("t6.run.busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkStatus("t6.ignored", 1'b1, 1'b0, 1'b0, 1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t5.pre.out", 32'(outPulse), 32'd0);

        abort   = 1'b1;
        inBit   = 1'b1;
        inValid = 1'b1;
        tick();
        abort   = 1'b0;
        inValid = 1'b0;
        checkStatus("t5.abort", 1'b0, 1'b0, 1'b0, 1, 1'b0);
        tick();
        checkStatus("t5.abort2", 1'b0, 1'b0, 1'b0, 1, 1'b0);

        // Config write while idle with len=0 becomes a one-bit pattern
        applyConfig(8'h01, 4'd0, 8'd3, 1'b1, 16'd0);
        checkOutput("t6.idle.cfgErr", 32'(cfgErr), 32'd1);
        startRun();
        checkOutput("t6.start.cfgErr", 32'(cfgErr), 32'd0);
        bits6 = 4'b1011;
        outs6 = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(bits6[i], 1'b1);
            checkOutput("t6.out", 32'(outPulse), 32'(outs6[i]));
        end
        checkStatus("t6.end", 1'b0, 1'b1, 1'b1, 3, 1'b0);
        tick();
        checkStatus("t6.idle", 1'b0, 1'b0, 1'b0, 3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
